// File: rtl/irq_aggregator.sv
// Avalon-MM interrupt aggregator: per-source edge/level capture, pending latch, mask,
// one combined IRQ and a priority-encoded ACTIVE register. Define IRQ_AGG_SYNC_EN to add a 2-flop input synchronizer.
module irq_aggregator #(
    parameter int          NUM_SRC    = 4,
    parameter logic [15:0] MODE_RESET = 16'h0000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    input  logic [NUM_SRC-1:0] irq_in,
    output logic               irq_out
);

    typedef enum logic [2:0] {
        REG_STATUS  = 3'd0,
        REG_MASK    = 3'd1,
        REG_MODE    = 3'd2,
        REG_RAW     = 3'd3,
        REG_ACTIVE  = 3'd4,
        REG_OVERRUN = 3'd5,
        REG_FORCE   = 3'd6,
        REG_RSVD    = 3'd7
    } reg_addr_e;

    // Bits at or above NUM_SRC are tied to zero everywhere through this mask.
    localparam logic [15:0] SRC_MASK = 16'((17'd1 << NUM_SRC) - 17'd1);

    logic [15:0] irq_ext;
    logic [15:0] raw_sample;

    logic [15:0] raw_q;
    logic [15:0] raw_prev;
    logic [15:0] pending;
    logic [15:0] mask_q;
    logic [15:0] mode_q;
    logic [15:0] overrun_cnt;

    logic        bus_wr;
    logic        wr_status;
    logic        wr_mask;
    logic        wr_mode;
    logic        wr_overrun;
    logic        wr_force;

    logic [15:0] rise;
    logic [15:0] clr_bits;
    logic [15:0] force_bits;
    logic [15:0] pending_nxt;
    logic [15:0] active_bits;
    logic        active_valid;
    logic [3:0]  active_id;
    logic        overrun_hit;
    logic [15:0] overrun_nxt;
    logic [15:0] rd_mux;

    assign irq_ext = 16'(irq_in) & SRC_MASK;

`ifdef IRQ_AGG_SYNC_EN
    logic [15:0] sync_q1;
    logic [15:0] sync_q2;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= irq_ext;
            sync_q2 <= sync_q1;
        end
    end

    assign raw_sample = sync_q2;
`else
    assign raw_sample = irq_ext;
`endif

    assign bus_wr     = chipselect & ~write_n;
    assign wr_status  = bus_wr & (address == REG_STATUS);
    assign wr_mask    = bus_wr & (address == REG_MASK);
    assign wr_mode    = bus_wr & (address == REG_MODE);
    assign wr_overrun = bus_wr & (address == REG_OVERRUN);
    assign wr_force   = bus_wr & (address == REG_FORCE);

    // raw_prev is cleared by reset, so a line already high at release reads as an edge.
    assign rise       = raw_q & ~raw_prev;
    assign clr_bits   = {16{wr_status}} & writedata & SRC_MASK;
    assign force_bits = {16{wr_force}} & writedata & SRC_MASK;

    always_comb begin
        // NOTE: every always_comb output gets a default before any branch, so no latch can be inferred.
        pending_nxt = pending;
        for (int i = 0; i < 16; i++) begin
            if (mode_q[i]) begin
                if (rise[i] | force_bits[i]) begin
                    pending_nxt[i] = 1'b1;
                end else if (clr_bits[i]) begin
                    pending_nxt[i] = 1'b0;
                end
            end else begin
                pending_nxt[i] = raw_q[i] | force_bits[i];
            end
        end
        pending_nxt = pending_nxt & SRC_MASK;
    end

    // An edge landing on an already-pending edge-mode bit is lost unless that bit is being cleared.
    assign overrun_hit = |(mode_q & rise & pending & ~clr_bits);

    always_comb begin
        overrun_nxt = overrun_cnt;
        if (wr_overrun) begin
            overrun_nxt = '0;
        end else if (overrun_hit && (overrun_cnt != 16'hFFFF)) begin
            overrun_nxt = overrun_cnt + 16'd1;
        end
    end

    assign active_bits  = pending & mask_q;
    assign active_valid = |active_bits;

    always_comb begin
        active_id = '0;
        for (int i = 15; i >= 0; i--) begin
            if (active_bits[i]) begin
                active_id = 4'(i);
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            REG_STATUS:  rd_mux = active_bits;
            REG_MASK:    rd_mux = mask_q;
            REG_MODE:    rd_mux = mode_q;
            REG_RAW:     rd_mux = raw_q;
            REG_ACTIVE:  rd_mux = {active_valid, 11'b0, active_id};
            REG_OVERRUN: rd_mux = overrun_cnt;
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            raw_q       <= '0;
            raw_prev    <= '0;
            pending     <= '0;
            mask_q      <= '0;
            mode_q      <= MODE_RESET & SRC_MASK;
            overrun_cnt <= '0;
            irq_out     <= 1'b0;
            readdata    <= '0;
        end else begin
            raw_q       <= raw_sample;
            raw_prev    <= raw_q;
            pending     <= pending_nxt;
            overrun_cnt <= overrun_nxt;
            irq_out     <= |active_bits;
            readdata    <= rd_mux;
            if (wr_mask) begin
                mask_q <= writedata & SRC_MASK;
            end
            if (wr_mode) begin
                mode_q <= writedata & SRC_MASK;
            end
        end
    end

endmodule
